// File: rtl/alu_div_frontend.sv
// Signed/unsigned 8-bit divide front-end: operand magnitude conversion, divider launch,
// watchdog, local divide-by-zero / overflow bypass and sign correction of the result.
module alu_div_frontend #(
  parameter int TIMEOUT_CYC = 64,
  parameter int TW          = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_signed,
  input  logic [7:0] req_dividend,
  input  logic [7:0] req_divisor,
  output logic       div_start,
  output logic [7:0] div_dividend,
  output logic [7:0] div_divisor,
  input  logic       div_done,
  input  logic [7:0] div_quotient,
  input  logic [7:0] div_remainder,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_quotient,
  output logic [7:0] rsp_remainder,
  output logic       rsp_div_by0,
  output logic       rsp_overflow,
  output logic       rsp_timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FIX    = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]    state_reg;
  logic          qneg_reg;
  logic          rneg_reg;
  logic [7:0]    dd_mag_reg;
  logic [7:0]    dv_mag_reg;
  logic [7:0]    uq_reg;
  logic [7:0]    ur_reg;
  logic [TW-1:0] wd_reg;
  logic [7:0]    q_reg;
  logic [7:0]    r_reg;
  logic          by0_reg;
  logic          ovf_reg;
  logic          tmo_reg;

  logic          dd_neg;
  logic          dv_neg;
  logic [7:0]    dd_mag;
  logic [7:0]    dv_mag;
  logic [TW-1:0] wd_inc;
  logic          wd_expire;

  // Negating 8'h80 wraps back to 8'h80, which is the unsigned magnitude wanted.
  assign dd_neg    = req_signed & req_dividend[7];
  assign dv_neg    = req_signed & req_divisor[7];
  assign dd_mag    = dd_neg ? 8'(-req_dividend) : req_dividend;
  assign dv_mag    = dv_neg ? 8'(-req_divisor)  : req_divisor;
  assign wd_inc    = wd_reg + 1'b1;
  assign wd_expire = (wd_inc == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      qneg_reg   <= 1'b0;
      rneg_reg   <= 1'b0;
      dd_mag_reg <= 8'h00;
      dv_mag_reg <= 8'h00;
      uq_reg     <= 8'h00;
      ur_reg     <= 8'h00;
      wd_reg     <= '0;
      q_reg      <= 8'h00;
      r_reg      <= 8'h00;
      by0_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
      tmo_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            qneg_reg   <= dd_neg ^ dv_neg;
            rneg_reg   <= dd_neg;
            dd_mag_reg <= dd_mag;
            dv_mag_reg <= dv_mag;
            // Divide-by-zero is tested first so it wins over the -128/-1 case.
            if (req_divisor == 8'h00) begin
              q_reg     <= 8'hFF;
              r_reg     <= 8'hFF;
              by0_reg   <= 1'b1;
              state_reg <= S_RESP;
            end else if (req_signed && req_dividend == 8'h80 && req_divisor == 8'hFF) begin
              q_reg     <= 8'h80;
              r_reg     <= 8'h00;
              ovf_reg   <= 1'b1;
              state_reg <= S_RESP;
            end else begin
              state_reg <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          wd_reg    <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          wd_reg <= wd_inc;
          if (div_done) begin
            uq_reg    <= div_quotient;
            ur_reg    <= div_remainder;
            state_reg <= S_FIX;
          end else if (wd_expire) begin
            q_reg     <= 8'h00;
            r_reg     <= 8'h00;
            tmo_reg   <= 1'b1;
            state_reg <= S_RESP;
          end
        end
        S_FIX: begin
          q_reg     <= qneg_reg ? 8'(-uq_reg) : uq_reg;
          r_reg     <= rneg_reg ? 8'(-ur_reg) : ur_reg;
          state_reg <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            by0_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            tmo_reg   <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_reg == S_IDLE);
  assign div_start     = (state_reg == S_LAUNCH);
  assign div_dividend  = dd_mag_reg;
  assign div_divisor   = dv_mag_reg;
  assign rsp_valid     = (state_reg == S_RESP);
  assign rsp_quotient  = q_reg;
  assign rsp_remainder = r_reg;
  assign rsp_div_by0   = by0_reg;
  assign rsp_overflow  = ovf_reg;
  assign rsp_timeout   = tmo_reg;

endmodule
